// File: rtl/lfsr_picker_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_picker_pkg
// Shared types and helpers for lfsr_range_picker:
//   pick_state_t   - picker FSM states (PICK_IDLE..PICK_OUT)
//   range_mask()   - smallest 2^k-1 that covers rng-1
//   all_ones_seed()- XNOR LFSR lock-up pattern for a given width
// ---------------------------------------------------------------------------
package lfsr_picker_pkg;

  typedef enum logic [2:0] {
    PICK_IDLE  = 3'd0,
    PICK_SEED  = 3'd1,
    PICK_STEP  = 3'd2,
    PICK_CHECK = 3'd3,
    PICK_OUT   = 3'd4
  } pick_state_t;

  // Grows the mask one bit at a time until it covers rng-1; rng==0 or 1
  // both yield 0 so a single legal value always maps to candidate 0.
  function automatic logic [31:0] range_mask(input logic [31:0] rng);
    logic [31:0] m;
    logic [31:0] lim;
    m   = '0;
    lim = (rng == '0) ? '0 : rng - 32'd1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (m < lim) m = {m[30:0], 1'b1};
    end
    return m;
  endfunction

  // All-ones word of the given width: the state an XNOR LFSR never leaves.
  function automatic logic [31:0] all_ones_seed(input int unsigned nbits);
    return (nbits >= 32) ? '1 : ((32'd1 << nbits) - 32'd1);
  endfunction

endpackage

// File: rtl/lfsr_picker_mask.sv
// ---------------------------------------------------------------------------
// lfsr_picker_mask
// Combinational mask generator for rejection sampling.
// Ports:
//   i_Range [OUT_BITS] - number of legal values (already forced >= 1)
//   o_Mask  [OUT_BITS] - smallest 2^k-1 that is >= i_Range-1
// ---------------------------------------------------------------------------
module lfsr_picker_mask
  import lfsr_picker_pkg::*;
#(
  parameter int unsigned OUT_BITS = 4
) (
  input  logic [OUT_BITS-1:0] i_Range,
  output logic [OUT_BITS-1:0] o_Mask
);

  logic [31:0] w_Range_Ext;
  logic [31:0] w_Mask_Full;

  always_comb begin
    w_Range_Ext                 = '0;
    w_Range_Ext[OUT_BITS-1:0]   = i_Range;
  end

  assign w_Mask_Full = range_mask(w_Range_Ext);
  assign o_Mask      = w_Mask_Full[OUT_BITS-1:0];

  // Upper mask bits are always zero for an OUT_BITS-wide range.
  generate
    if (OUT_BITS < 32) begin : g_hi
      logic w_unused_mask_hi;
      assign w_unused_mask_hi = ^w_Mask_Full[31:OUT_BITS];
    end
  endgenerate

endmodule

// File: rtl/lfsr_range_picker.sv
// ---------------------------------------------------------------------------
// lfsr_range_picker
// Turns raw XNOR-LFSR words into uniform integers in [0, range-1] by
// rejection sampling. Owns the LFSR's enable/seed inputs so the LFSR only
// advances when a candidate is needed.
//
// Optional feature: define LFSR_PICKER_NO_REPEAT_EN to reject a candidate
// equal to the previously delivered value (when range > 1) and to use
// (last+1) mod range as the fallback value.
//
// Ports:
//   i_Clk, i_Rst           - clock, async active-high reset
//   i_Seed_Load, i_Seed    - reseed request and seed value
//   i_Req, i_Range         - draw request and number of legal values
//   i_Ready                - consumer accepts o_Value
//   o_Valid, o_Value       - result handshake and value
//   o_Fallback             - result came from fallback, not the LFSR
//   o_Busy                 - FSM not idle
//   o_LFSR_Enable          - to LFSR i_Enable
//   o_LFSR_Seed_DV         - to LFSR i_Seed_DV
//   o_LFSR_Seed_Data       - to LFSR i_Seed_Data
//   i_LFSR_Data            - from LFSR o_LFSR_Data
// ---------------------------------------------------------------------------
module lfsr_range_picker
  import lfsr_picker_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned OUT_BITS  = 4,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Seed_Load,
  input  logic [NUM_BITS-1:0] i_Seed,
  input  logic                i_Req,
  input  logic [OUT_BITS-1:0] i_Range,
  input  logic                i_Ready,
  output logic                o_Valid,
  output logic [OUT_BITS-1:0] o_Value,
  output logic                o_Fallback,
  output logic                o_Busy,
  output logic                o_LFSR_Enable,
  output logic                o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
  input  logic [NUM_BITS-1:0] i_LFSR_Data
);

  localparam int unsigned         TRY_W       = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]    TRY_LIMIT   = TRY_W'(MAX_TRIES);
  localparam logic [31:0]         SEED_LOCK32 = all_ones_seed(NUM_BITS);
  localparam logic [NUM_BITS-1:0] SEED_LOCKUP = SEED_LOCK32[NUM_BITS-1:0];

  pick_state_t         r_State;
  pick_state_t         w_Next;

  logic [OUT_BITS-1:0] r_Rng;
  logic [OUT_BITS-1:0] r_Value;
  logic                r_Fallback;
  logic [TRY_W-1:0]    r_Tries;
  logic [NUM_BITS-1:0] r_Seed_Data;

  logic [OUT_BITS-1:0] w_Mask;
  logic [OUT_BITS-1:0] w_Cand;
  logic [OUT_BITS-1:0] w_Fallback_Val;
  logic [TRY_W-1:0]    w_Tries_Inc;
  logic                w_Accept;
  logic                w_Exhausted;

  lfsr_picker_mask #(
    .OUT_BITS(OUT_BITS)
  ) u_mask (
    .i_Range(r_Rng),
    .o_Mask (w_Mask)
  );

  assign w_Cand      = i_LFSR_Data[OUT_BITS-1:0] & w_Mask;
  assign w_Tries_Inc = r_Tries + TRY_W'(1);
  assign w_Exhausted = (w_Tries_Inc == TRY_LIMIT);

  // Only the low OUT_BITS of the LFSR word feed the candidate.
  generate
    if (NUM_BITS > OUT_BITS) begin : g_lfsr_hi
      logic w_unused_lfsr_hi;
      assign w_unused_lfsr_hi = ^i_LFSR_Data[NUM_BITS-1:OUT_BITS];
    end
  endgenerate

`ifdef LFSR_PICKER_NO_REPEAT_EN
  logic [OUT_BITS-1:0] r_Last;

  // r_Last is compared as stored, even when it lies outside the new range.
  assign w_Accept = (w_Cand < r_Rng) &&
                    !((w_Cand == r_Last) && (r_Rng > OUT_BITS'(1)));
  assign w_Fallback_Val =
    OUT_BITS'(({1'b0, r_Last} + {{OUT_BITS{1'b0}}, 1'b1}) % {1'b0, r_Rng});

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Last <= '0;
    end else if ((r_State == PICK_OUT) && i_Ready) begin
      r_Last <= r_Value;
    end
  end
`else
  assign w_Accept       = (w_Cand < r_Rng);
  assign w_Fallback_Val = '0;
`endif

  // State register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= PICK_IDLE;
    end else begin
      r_State <= w_Next;
    end
  end

  // Next-state logic
  always_comb begin
    w_Next = r_State;
    case (r_State)
      PICK_IDLE: begin
        if (i_Seed_Load) begin
          w_Next = PICK_SEED;
        end else if (i_Req) begin
          w_Next = PICK_STEP;
        end
      end
      PICK_SEED:  w_Next = PICK_IDLE;
      PICK_STEP:  w_Next = PICK_CHECK;
      PICK_CHECK: begin
        if (w_Accept || w_Exhausted) begin
          w_Next = PICK_OUT;
        end else begin
          w_Next = PICK_STEP;
        end
      end
      PICK_OUT: begin
        if (i_Ready) w_Next = PICK_IDLE;
      end
      default: w_Next = PICK_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Rng       <= '0;
      r_Value     <= '0;
      r_Fallback  <= 1'b0;
      r_Tries     <= '0;
      r_Seed_Data <= '0;
    end else begin
      case (r_State)
        PICK_IDLE: begin
          if (i_Seed_Load) begin
            // Seeding the XNOR lock-up state would freeze the LFSR.
            r_Seed_Data <= (i_Seed == SEED_LOCKUP) ? '0 : i_Seed;
          end else if (i_Req) begin
            r_Rng   <= (i_Range == '0) ? OUT_BITS'(1) : i_Range;
            r_Tries <= '0;
          end
        end
        PICK_CHECK: begin
          if (w_Accept) begin
            r_Value    <= w_Cand;
            r_Fallback <= 1'b0;
          end else begin
            r_Tries <= w_Tries_Inc;
            if (w_Exhausted) begin
              r_Value    <= w_Fallback_Val;
              r_Fallback <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the registered state
  assign o_Valid          = (r_State == PICK_OUT);
  assign o_Busy           = (r_State != PICK_IDLE);
  assign o_LFSR_Enable    = (r_State == PICK_SEED) || (r_State == PICK_STEP);
  assign o_LFSR_Seed_DV   = (r_State == PICK_SEED);
  assign o_LFSR_Seed_Data = (r_State == PICK_SEED) ? r_Seed_Data : '0;
  assign o_Value          = r_Value;
  assign o_Fallback       = r_Fallback;

endmodule

// File: tb/tb_lfsr_range_picker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_range_picker
// Directed and randomized checks of lfsr_range_picker with the LFSR replaced
// by a stub that presents the next queued word whenever a STEP enable edge
// occurs. Expected results come from an arithmetic rejection-sampling model.
// ---------------------------------------------------------------------------
module tb_lfsr_range_picker;

  localparam int unsigned NB = 8;
  localparam int unsigned OB = 4;
  localparam int unsigned MT = 16;
`ifdef LFSR_PICKER_NO_REPEAT_EN
  localparam bit NO_REP = 1'b1;
`else
  localparam bit NO_REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_load;
  logic [NB-1:0] seed;
  logic          req;
  logic [OB-1:0] range_in;
  logic          ready;
  logic          valid;
  logic [OB-1:0] value;
  logic          fallback;
  logic          busy;
  logic          lfsr_en;
  logic          lfsr_dv;
  logic [NB-1:0] lfsr_seed;
  logic [NB-1:0] lfsr_data;

  always #5 clk = ~clk;

  lfsr_range_picker #(
    .NUM_BITS (NB),
    .OUT_BITS (OB),
    .MAX_TRIES(MT)
  ) dut (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .i_Seed_Load     (seed_load),
    .i_Seed          (seed),
    .i_Req           (req),
    .i_Range         (range_in),
    .i_Ready         (ready),
    .o_Valid         (valid),
    .o_Value         (value),
    .o_Fallback      (fallback),
    .o_Busy          (busy),
    .o_LFSR_Enable   (lfsr_en),
    .o_LFSR_Seed_DV  (lfsr_dv),
    .o_LFSR_Seed_Data(lfsr_seed),
    .i_LFSR_Data     (lfsr_data)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned en_cnt      = 0;
  int unsigned model_last  = 0;
  logic [7:0]  stub_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock: count enable pulses and emulate the LFSR advancing on STEP.
  task automatic step();
    logic en, dv;
    en = lfsr_en;
    dv = lfsr_dv;
    @(posedge clk);
    #1;
    if (en === 1'b1) begin
      en_cnt++;
      if (dv !== 1'b1 && stub_q.size() > 0) lfsr_data = stub_q.pop_front();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    32'(valid),     32'd0);
    check({tag, "_value"},    32'(value),     32'd0);
    check({tag, "_fallback"}, 32'(fallback),  32'd0);
    check({tag, "_busy"},     32'(busy),      32'd0);
    check({tag, "_en"},       32'(lfsr_en),   32'd0);
    check({tag, "_dv"},       32'(lfsr_dv),   32'd0);
    check({tag, "_seed"},     32'(lfsr_seed), 32'd0);
  endtask

  task automatic reseed(input logic [NB-1:0] s, input logic [NB-1:0] exp_s,
                        input string tag);
    seed      = s;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check({tag, "_dv"},   32'(lfsr_dv),   32'd1);
    check({tag, "_en"},   32'(lfsr_en),   32'd1);
    check({tag, "_data"}, 32'(lfsr_seed), 32'(exp_s));
    check({tag, "_busy"}, 32'(busy),      32'd1);
    step();
    check({tag, "_dv_end"},   32'(lfsr_dv), 32'd0);
    check({tag, "_busy_end"}, 32'(busy),    32'd0);
  endtask

  // Full draw: model the expected result from the queued stub words, issue
  // the request, wait for o_Valid, hold backpressure, then hand shake.
  task automatic draw(input int unsigned rin, input int unsigned hold,
                      input string tag);
    logic [7:0]  w[$];
    int unsigned rng, mask, word, cand, m_val, m_fb, m_en, cyc;
    w   = stub_q;
    rng = (rin == 0) ? 1 : rin;
    mask = 0;
    while (mask + 1 < rng) mask = mask * 2 + 1;
    m_fb  = 1;
    m_en  = MT;
    m_val = NO_REP ? (model_last + 1) % rng : 0;
    for (int unsigned k = 0; k < MT; k++) begin
      word = (k < w.size()) ? int'(w[k]) : int'(w[w.size() - 1]);
      // mask+1 is a power of two, so the modulo keeps exactly the low bits.
      cand = (word % (1 << OB)) % (mask + 1);
      if (cand < rng && !(NO_REP && rng > 1 && cand == model_last)) begin
        m_val = cand;
        m_fb  = 0;
        m_en  = k + 1;
        break;
      end
    end

    range_in = OB'(rin);
    req      = 1'b1;
    en_cnt   = 0;
    step();
    req = 1'b0;
    cyc = 1;  // cycles counted from the request cycle
    while (valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, "_valid"},    32'(valid),    32'd1);
    check({tag, "_latency"},  cyc,           1 + 2 * m_en);
    check({tag, "_value"},    32'(value),    m_val);
    check({tag, "_fallback"}, 32'(fallback), m_fb);
    check({tag, "_enables"},  en_cnt,        m_en);

    for (int unsigned h = 0; h < hold; h++) begin
      req = (h % 2 == 0);
      step();
      check({tag, "_hold_valid"}, 32'(valid), 32'd1);
      check({tag, "_hold_value"}, 32'(value), m_val);
      check({tag, "_hold_busy"},  32'(busy),  32'd1);
    end
    req   = 1'b0;
    ready = 1'b1;
    step();
    ready = 1'b0;
    check({tag, "_drop"},      32'(valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy),  32'd0);
    model_last = m_val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    seed_load = 1'b0;
    seed      = '0;
    req       = 1'b0;
    range_in  = '0;
    ready     = 1'b0;
    lfsr_data = 8'h00;
    #2;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();

    reseed(8'hFF, 8'h00, "seed_ff");
    reseed(8'h5A, 8'h5A, "seed_5a");

    stub_q = '{8'h23};
    draw(6, 0, "accept");
    stub_q = '{8'h07, 8'h02};
    draw(6, 0, "rej_acc");
    stub_q = '{8'h0F};
    draw(5, 0, "fallback");
    stub_q = '{8'h0E};
    draw(0, 1, "range0");
    stub_q = '{8'h25};
    draw(10, 10, "backpressure");

    // Reset while in CHECK abandons the draw at once.
    stub_q   = '{8'h03};
    range_in = 4'd6;
    req      = 1'b1;
    step();
    req = 1'b0;
    step();
    check("mid_busy",  32'(busy),    32'd1);
    check("mid_en",    32'(lfsr_en), 32'd0);
    check("mid_value", 32'(value),   32'd5);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    rst        = 1'b0;
    model_last = 0;
    stub_q.delete();
    step();

    // Seed load wins over a simultaneous request, and the request is lost.
    seed      = 8'h3C;
    seed_load = 1'b1;
    req       = 1'b1;
    range_in  = 4'd3;
    step();
    seed_load = 1'b0;
    req       = 1'b0;
    check("both_dv",   32'(lfsr_dv),   32'd1);
    check("both_data", 32'(lfsr_seed), 32'h3C);
    step();
    check("both_idle", 32'(busy), 32'd0);
    step();
    check("both_noreq", 32'(busy), 32'd0);

    for (int unsigned n = 0; n < 24; n++) begin
      int unsigned nw;
      stub_q.delete();
      nw = $urandom_range(1, 6);
      for (int unsigned j = 0; j < nw; j++) stub_q.push_back(8'($urandom));
      draw($urandom_range(0, 15), $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_range_picker.md
# lfsr_range_picker

Converts the raw pseudo-random words of the width-parameterised XNOR LFSR into uniformly distributed integers in `[0, range-1]` using rejection sampling. It sits directly downstream of the LFSR and owns that LFSR's `i_Enable`, `i_Seed_DV` and `i_Seed_Data` inputs, so the LFSR advances only when a draw is needed. Results go to game/control logic through a valid/ready handshake.

## Interface
- `NUM_BITS`, 8: LFSR width; must equal the connected LFSR's `NUM_BITS`; 3..32.
- `OUT_BITS`, 4: result width; `OUT_BITS <= NUM_BITS`.
- `MAX_TRIES`, 16: rejected candidates allowed before fallback; 1..255.
- `i_Clk`, in, 1: single clock; LFSR on the same clock.
- `i_Rst`, in, 1: asynchronous, active-high reset.
- `i_Seed_Load`, in, 1: request to reseed the LFSR.
- `i_Seed`, in, NUM_BITS: seed value.
- `i_Req`, in, 1: draw request; accepted only in IDLE.
- `i_Range`, in, OUT_BITS: number of legal values; sampled at request acceptance.
- `i_Ready`, in, 1: consumer accepts `o_Value`.
- `o_Valid`, out, 1: `o_Value` is valid.
- `o_Value`, out, OUT_BITS: drawn value.
- `o_Fallback`, out, 1: qualifies `o_Valid`; value came from fallback, not the LFSR.
- `o_Busy`, out, 1: FSM not in IDLE.
- `o_LFSR_Enable`, out, 1: to LFSR `i_Enable`.
- `o_LFSR_Seed_DV`, out, 1: to LFSR `i_Seed_DV`.
- `o_LFSR_Seed_Data`, out, NUM_BITS: to LFSR `i_Seed_Data`.
- `i_LFSR_Data`, in, NUM_BITS: from LFSR `o_LFSR_Data`.

## Operation
- **States:** IDLE, SEED, STEP, CHECK, OUT.
- **IDLE:**
  - If `i_Seed_Load` is high, go to SEED. Seed load has priority over `i_Req` when both are high in the same cycle.
  - Else if `i_Req` is high: latch `rng = (i_Range==0) ? 1 : i_Range`, clear the try counter, go to STEP.
  - `i_Req` in any other state is ignored; it is not queued.
- **SEED:** one cycle with `o_LFSR_Enable=1`, `o_LFSR_Seed_DV=1`.
  - `o_LFSR_Seed_Data = i_Seed`, except an all-ones seed (the XNOR lock-up state) is replaced by 0.
  - Next state: IDLE.
- **STEP:** one cycle with `o_LFSR_Enable=1`; the LFSR advances at the end of the cycle. Next state: CHECK.
- **CHECK:**
  - `mask` = smallest 2^k-1 that is >= `rng-1`.
  - `cand = i_LFSR_Data[OUT_BITS-1:0] & mask`.
  - Accept if `cand < rng`: register `o_Value=cand`, `o_Fallback=0`, go to OUT.
  - Reject otherwise: increment tries. If tries reaches MAX_TRIES, register the fallback value with `o_Fallback=1` and go to OUT; else go to STEP.
- **Fallback value:** 0.
- **OUT:** `o_Valid=1`; `o_Value` and `o_Fallback` are held stable until `i_Ready`.
  - On `o_Valid & i_Ready`: store `last=o_Value`, go to IDLE.
- **Width rules:** the try counter is `$clog2(MAX_TRIES+1)` bits. The mask is computed over OUT_BITS bits.
- **`rng==1`:** mask is 0, the first candidate is 0 and is always accepted.
- **Reset mid-operation:** abandons the draw. `last` is cleared to 0. The LFSR state is untouched, because the LFSR has no reset.

## Timing
- **Reset values:** state IDLE; `o_Valid`, `o_Value`, `o_Fallback`, `o_Busy`, `o_LFSR_Enable`, `o_LFSR_Seed_DV`, `o_LFSR_Seed_Data` all 0.
- **Draw latency:** request sampled at edge k gives STEP in cycle k+1 and CHECK in k+2. On first-try acceptance, `o_Valid` rises after edge k+3. Each rejection adds 2 cycles.
- **Worst case:** `o_Valid` after 3 + 2·(MAX_TRIES-1) cycles.
- **Handshake:** `o_Valid` drops the cycle after the `i_Ready` handshake edge. A new `i_Req` is accepted no earlier than the following edge.
- **Reseed:** `i_Seed_Load` in IDLE takes 1 cycle; `o_Busy` is high in that cycle.
- **Output registering:** `o_LFSR_Enable` and `o_LFSR_Seed_DV` are Moore outputs decoded from the registered state; they are never combinational from inputs.

## Configuration
- **`LFSR_PICKER_NO_REPEAT_EN` defined:**
  - In CHECK, a candidate equal to `last` is also rejected when `rng > 1`.
  - Fallback value becomes `(last+1) mod rng`.
  - `last` is compared as stored, even if it is `>= rng`.
- **Undefined:** repeats are allowed, fallback is 0, and `last` is not implemented.

## Structure
- **Package `lfsr_picker_pkg`:**
  - state enum;
  - `PICK_IDLE..PICK_OUT` encodings;
  - function `range_mask(rng)`;
  - all-ones seed constant helper.
- **Sub-module `lfsr_picker_mask`:** combinational, OUT_BITS in/out, computes the mask. The LFSR itself is instantiated beside the picker by the parent, not inside it.

## Test plan
- **Reseed:** reset, then pulse `i_Seed_Load` with `i_Seed=8'hFF`. Expect `o_LFSR_Seed_DV=1` for exactly 1 cycle with `o_LFSR_Seed_Data=8'h00`. Repeat with `8'h5A`: expect `8'h5A`.
- **Accept path:** stub `i_LFSR_Data=8'h23`, `i_Range=6`. Mask is 7, cand=3, so `o_Value=3`, `o_Fallback=0`, `o_Valid` 3 cycles after the request, exactly one `o_LFSR_Enable` pulse.
- **Reject then accept:** stub `8'h07` then `8'h02`, range 6. Expect 2 enable pulses, `o_Value=2`, latency 5.
- **Fallback:** stub constant `8'h0F`, range 5, MAX_TRIES=16. Expect 16 enable pulses, then `o_Value=0`, `o_Fallback=1`. With NO_REPEAT and `last=4`: expect `o_Value=0`.
- **Backpressure:** hold `i_Ready=0` for 10 cycles. `o_Value` stays stable, `i_Req` pulses are ignored, `o_Busy=1`. Release `i_Ready`: `o_Valid` drops the next cycle.
- **Corner cases:** `i_Range=0` yields `o_Value=0`. Asserting `i_Rst` in CHECK gives all outputs 0 immediately (asynchronously). `i_Seed_Load` and `i_Req` together produce SEED first.
